blur_line_buffer: RTL and testbench
===================================

# blur_line_buffer

Three-row line-buffer sequencer that turns the camera's single-pixel RGB565 raster stream into the 3-pixel vertical column that the 3x3 Gaussian blur stage consumes each cycle. It sits between the pixel source (camera or downsampler) and the blur stage. It stores the two previous rows, rotates row ownership at each line end, clamps the top and bottom image edges, and re-tags every column with the hcount/vcount of the centre pixel.

## Interface
Parameters:
- HRES, 320: active pixels per line; hcount_in values >= HRES are ignored.
- VRES, 180: active lines per frame; vcount_in values >= VRES are ignored.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- pixel_data_in  input  16  RGB565 pixel.
- hcount_in  input  11  pixel column.
- vcount_in  input  10  pixel row.
- data_valid_in  input  1  pixel/count qualifier, one pixel per cycle max.
- line_buffer_out  output  3x16  [0]=row above centre, [1]=centre row, [2]=row below, same column.
- hcount_out  output  11  column of the centre pixel.
- vcount_out  output  10  row of the centre pixel.
- data_valid_out  output  1  qualifier for the three outputs above.

## Operation
- Three line RAMs, each HRES x 16, with a 2-cycle registered read. Index wr_sel (2 bits, 0..2) names the RAM receiving the current row.
- Accepted pixel: data_valid_in=1, hcount_in<HRES and vcount_in<VRES. Pixels outside these limits are ignored: no write, no pointer change, no output.
- Per accepted pixel:
  - Write pixel_data_in to RAM[wr_sel] at address hcount_in.
  - Read address hcount_in from RAM[(wr_sel+1)%3] (row v-2) and RAM[(wr_sel+2)%3] (row v-1).
- Pointer advance:
  - Accepted pixel with hcount_in==HRES-1: wr_sel <= (wr_sel+1)%3, evaluated after that pixel's write and read are issued.
  - wr_sel never takes the value 3.
  - wr_sel does not reset at frame start; rotation is continuous.
- Centre row is v-1. Output counts:
  - hcount_out = hcount_in.
  - vcount_out = vcount_in-1, wrapping vcount_in=0 to VRES-1 (last row of the previous frame).
- Edge clamping, applied in the final stage:
  - vcount_out==0: out[0] <= centre pixel (row -1 replicated).
  - vcount_out==VRES-1: out[2] <= centre pixel (row VRES, which is the next frame's row 0, is not used).
  - VRES==1 is not supported.
- Arithmetic: pointer sums are mod 3, computed as 2-bit compare-and-subtract. vcount decrement is 10-bit with an explicit wrap compare, not an underflow.
- RAM contents are not cleared by reset. Outputs that depend on rows never written since reset are don't-care. The bench must ignore the first two rows after reset.

## Timing
- Latency: exactly 2 cycles, data_valid_in to data_valid_out. Throughput: 1 pixel per cycle, no back-pressure.
- The current pixel, both counts, the valid bit, and the edge flags travel through a 2-stage register pipeline matched to the RAM read latency.
- Read-during-write: the write and both reads always target three distinct RAMs, so no collision case exists.
- A valid gap (data_valid_in=0) inserts a bubble; output order is preserved.
- Line end followed by the next line's pixel 0 on the very next cycle: the pointer update must already be in effect for that pixel.
- Reset values: data_valid_out=0, hcount_out=0, vcount_out=0, line_buffer_out=0, wr_sel=0, pipeline valids=0.
- Reset mid-line: in-flight pixels are discarded, and no data_valid_out is produced for 2 cycles after reset deasserts.

## Structure
- Shared package blur_pkg:
  - typedef rgb565_t (16-bit).
  - constant KERNEL_SIZE=3, which also sizes line_buffer_out.
  - function mod3_inc.
- Sub-module line_ram: parameterised width/depth, single write port, 2-cycle registered read port. Instantiated 3 times; read and write addresses are muxed by wr_sel in the top.
- Top holds wr_sel, the mod-3 selection muxes, the 2-stage side pipeline, and edge clamping.

## Test plan
- Full 320x180 frame of pixel = {vcount[4:0], hcount[5:0], 5'd0}, continuous valid, after one warm-up frame -> at (h=10, v=50) outputs rows 49/50/51 at column 10, 2 cycles after input (h=10, v=51).
- Top edge: input (h=7, v=1) -> vcount_out=0 and out[0]==out[1]==row-0 pixel 7. Bottom edge: input (h=7, v=0) of the next frame -> vcount_out=179 and out[2]==out[1].
- Random 30% valid gaps across 3 lines -> output stream equals the gap-free golden model in order; every valid_out exactly 2 cycles after its valid_in.
- Out-of-range input: hcount_in=400 or vcount_in=200 with valid=1 -> no data_valid_out, wr_sel unchanged, no RAM write.
- Pointer rotation: 7 full lines -> wr_sel sequence 0,1,2,0,1,2,0,1, with each change on the cycle after the h=319 pixel.
- Reset asserted mid-line (h=150) for 1 cycle -> all outputs 0 next cycle, data_valid_out=0 for 2 cycles after release, wr_sel=0.

Source files
------------

// File: rtl/blur_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : blur_pkg
//  Purpose  : Shared types, constants and mod-3 pointer helper for the blur
//             line-buffer sequencer.
//  Revision : 1.0
// ============================================================================
package blur_pkg;

   typedef logic [15:0] rgb565_t;

   localparam int KERNEL_SIZE = 3;
   localparam int HCOUNT_W    = 11;
   localparam int VCOUNT_W    = 10;

   // One slot of the side pipeline that rides alongside the RAM read latency.
   typedef struct packed {
      logic                valid;
      rgb565_t             pixel;
      logic [HCOUNT_W-1:0] hcount;
      logic [VCOUNT_W-1:0] vcount;
      logic                top_edge;
      logic                bot_edge;
      logic [1:0]          sel;
   } stage_t;

   function automatic logic [1:0] mod3_inc(input logic [1:0] v);
      logic [1:0] s;
      s = v + 2'd1;
      if (s >= 2'd3) s = s - 2'd3;
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/blur_line_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : blur_line_buffer_if
//  Purpose  : Raster input stream and 3-row column output of the line buffer.
//  Revision : 1.0
// ============================================================================
interface blur_line_buffer_if;
   import blur_pkg::*;

   rgb565_t                         pixel_data_in;
   logic [HCOUNT_W-1:0]             hcount_in;
   logic [VCOUNT_W-1:0]             vcount_in;
   logic                            data_valid_in;

   rgb565_t [KERNEL_SIZE-1:0]       line_buffer_out;
   logic [HCOUNT_W-1:0]             hcount_out;
   logic [VCOUNT_W-1:0]             vcount_out;
   logic                            data_valid_out;

   modport master (
      output pixel_data_in, hcount_in, vcount_in, data_valid_in,
      input  line_buffer_out, hcount_out, vcount_out, data_valid_out
   );

   modport slave (
      input  pixel_data_in, hcount_in, vcount_in, data_valid_in,
      output line_buffer_out, hcount_out, vcount_out, data_valid_out
   );

endinterface
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
//  Module   : line_ram
//  Purpose  : One image line of storage; single write port, 2-cycle read.
//  Revision : 1.0
// ============================================================================
module line_ram #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 320,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  wire logic              clk_in,
   input  wire logic              we_in,
   input  wire logic [ADDR_W-1:0] waddr_in,
   input  wire logic [WIDTH-1:0]  wdata_in,
   input  wire logic [ADDR_W-1:0] raddr_in,
   output logic      [WIDTH-1:0]  rdata_out
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_q;
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_in) begin
      if (we_in) mem_q[waddr_in] <= wdata_in;
      rd_q    <= mem_q[raddr_in];
      rdata_q <= rd_q;
   end

   assign rdata_out = rdata_q;

endmodule
`default_nettype wire

// File: rtl/blur_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : blur_line_buffer
//  Purpose  : Rotating three-row line buffer feeding 3-pixel columns (with
//             top/bottom edge clamping) to the 3x3 blur stage.
//  Revision : 1.0
// ============================================================================
module blur_line_buffer
   import blur_pkg::*;
#(
   parameter int HRES = 320,
   parameter int VRES = 180
) (
   input wire logic           clk_in,
   input wire logic           rst_in,
   blur_line_buffer_if.slave  bus
);

   localparam int                  ADDR_W = $clog2(HRES);
   localparam logic [HCOUNT_W-1:0] H_LIM  = HCOUNT_W'(HRES);
   localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(HRES - 1);
   localparam logic [VCOUNT_W-1:0] V_LIM  = VCOUNT_W'(VRES);
   localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(VRES - 1);

   logic [1:0]          wr_sel_q, wr_sel_d;
   stage_t              s1_q, s1_d, s2_q;
   logic                accept;
   logic [VCOUNT_W-1:0] vcount_dec;
   rgb565_t             rdata [KERNEL_SIZE];
   rgb565_t             above, centre, below;

   always_comb begin
      accept     = bus.data_valid_in && (bus.hcount_in < H_LIM) && (bus.vcount_in < V_LIM);
      vcount_dec = (bus.vcount_in == '0) ? V_LAST : bus.vcount_in - VCOUNT_W'(1);

      wr_sel_d = wr_sel_q;
      if (accept && bus.hcount_in == H_LAST) wr_sel_d = mod3_inc(wr_sel_q);

      s1_d.valid    = accept;
      s1_d.pixel    = bus.pixel_data_in;
      s1_d.hcount   = bus.hcount_in;
      s1_d.vcount   = vcount_dec;
      s1_d.top_edge = (vcount_dec == '0);
      s1_d.bot_edge = (vcount_dec == V_LAST);
      s1_d.sel      = wr_sel_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_sel_q <= 2'd0;
         s1_q     <= '0;
         s2_q     <= '0;
      end else begin
         wr_sel_q <= wr_sel_d;
         s1_q     <= s1_d;
         s2_q     <= s1_q;
      end
   end

   // The row being written always lives in a different RAM from both rows read.
   for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_ram
      line_ram #(
         .WIDTH  ($bits(rgb565_t)),
         .DEPTH  (HRES),
         .ADDR_W (ADDR_W)
      ) u_ram (
         .clk_in    (clk_in),
         .we_in     (accept && (wr_sel_q == 2'(i))),
         .waddr_in  (bus.hcount_in[ADDR_W-1:0]),
         .wdata_in  (bus.pixel_data_in),
         .raddr_in  (bus.hcount_in[ADDR_W-1:0]),
         .rdata_out (rdata[i])
      );
   end

   always_comb begin
      above  = rdata[mod3_inc(s2_q.sel)];
      centre = rdata[mod3_inc(mod3_inc(s2_q.sel))];
      below  = s2_q.pixel;
      if (s2_q.top_edge) above = centre;
      if (s2_q.bot_edge) below = centre;

      bus.line_buffer_out = s2_q.valid ? {below, centre, above} : '0;
      bus.hcount_out      = s2_q.hcount;
      bus.vcount_out      = s2_q.vcount;
      bus.data_valid_out  = s2_q.valid;
   end

endmodule
`default_nettype wire

// File: tb/tb_blur_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blur_line_buffer
//  Purpose  : Directed raster-stream bench for blur_line_buffer.
//  Revision : 1.0
// ============================================================================
module tb_blur_line_buffer;

   localparam int HRES = 320;
   localparam int VRES = 180;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         total = 0;
   int         bad = 0;
   logic [1:0] exp_sel = 2'd0;

   blur_line_buffer_if bus();

   blur_line_buffer #(.HRES(HRES), .VRES(VRES)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pix(input int v, input int h);
      logic [9:0]  vv;
      logic [10:0] hh;
      vv = 10'(v);
      hh = 11'(h);
      return {vv[4:0], hh[5:0], 5'd0};
   endfunction

   function automatic logic [1:0] next_sel(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   task automatic px(input int h, input int v, input bit vld, input logic [15:0] d);
      bus.hcount_in     = 11'(h);
      bus.vcount_in     = 10'(v);
      bus.data_valid_in = vld;
      bus.pixel_data_in = d;
      @(posedge clk);
      #1;
   endtask

   // Streams whole lines; data is checked once both rows above are known.
   task automatic run_lines(input int v0, input int nl, input int gap_pct, input int chk_from);
      bit          pv, pchk, gap;
      int          ph, pvin, h, v, vo;
      logic [15:0] e0, e1, e2;
      pv = 0; pchk = 0; ph = 0; pvin = 0;
      for (int l = 0; l < nl; l++) begin
         v = (v0 + l) % VRES;
         h = 0;
         while (h < HRES) begin
            gap = (gap_pct > 0) && (int'($urandom_range(99)) < gap_pct);
            px(h, v, !gap, pix(v, h));
            if (!gap && h == HRES - 1) exp_sel = next_sel(exp_sel);
            total++;
            if (bus.data_valid_out !== pv) begin
               bad++;
               $display("FAIL stream_valid: got %0b want %0b (v=%0d h=%0d)", bus.data_valid_out, pv, v, h);
            end
            if (pv) begin
               vo = (pvin == 0) ? VRES - 1 : pvin - 1;
               total++;
               if (bus.hcount_out !== 11'(ph) || bus.vcount_out !== 10'(vo)) begin
                  bad++;
                  $display("FAIL stream_counts: got h=%0d v=%0d want h=%0d v=%0d",
                           bus.hcount_out, bus.vcount_out, ph, vo);
               end
               if (pchk) begin
                  e1 = pix(vo, ph);
                  e0 = (vo == 0) ? e1 : pix(vo - 1, ph);
                  e2 = (vo == VRES - 1) ? e1 : pix(pvin, ph);
                  total++;
                  if (bus.line_buffer_out !== {e2, e1, e0}) begin
                     bad++;
                     $display("FAIL stream_data: got %h want %h (centre v=%0d h=%0d)",
                              bus.line_buffer_out, {e2, e1, e0}, vo, ph);
                  end
               end
            end
            total++;
            if (dut.wr_sel_q !== exp_sel) begin
               bad++;
               $display("FAIL stream_wr_sel: got %0d want %0d (v=%0d h=%0d)", dut.wr_sel_q, exp_sel, v, h);
            end
            pv = !gap; ph = h; pvin = v; pchk = (l >= chk_from);
            if (!gap) h++;
         end
      end
      px(0, 0, 0, 16'h0);
      total++;
      if (bus.data_valid_out !== pv) begin
         bad++;
         $display("FAIL stream_tail: got %0b want %0b", bus.data_valid_out, pv);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      px(0, 0, 0, 16'h0);
      px(0, 0, 0, 16'h0);
      total++; if (bus.data_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", bus.data_valid_out); end
      total++; if (bus.hcount_out !== 11'd0) begin bad++; $display("FAIL reset_hcount: got %0d want 0", bus.hcount_out); end
      total++; if (bus.vcount_out !== 10'd0) begin bad++; $display("FAIL reset_vcount: got %0d want 0", bus.vcount_out); end
      total++; if (bus.line_buffer_out !== 48'h0) begin bad++; $display("FAIL reset_lbo: got %h want 0", bus.line_buffer_out); end
      total++; if (dut.wr_sel_q !== 2'd0) begin bad++; $display("FAIL reset_wr_sel: got %0d want 0", dut.wr_sel_q); end
      rst = 1'b0;
      exp_sel = 2'd0;
   endtask

   task automatic test_rotation();
      run_lines(0, 7, 0, 2);
      total++;
      if (dut.wr_sel_q !== 2'd1) begin bad++; $display("FAIL rotation_final: got %0d want 1", dut.wr_sel_q); end
   endtask

   task automatic test_column();
      run_lines(48, 3, 0, 2);
      for (int h = 0; h < HRES; h++) begin
         px(h, 51, 1, pix(51, h));
         if (h == 11) begin
            total++;
            if (bus.data_valid_out !== 1'b1 || bus.hcount_out !== 11'd10 || bus.vcount_out !== 10'd50) begin
               bad++;
               $display("FAIL col_counts: got vld=%0b h=%0d v=%0d want 1/10/50",
                        bus.data_valid_out, bus.hcount_out, bus.vcount_out);
            end
            total++; if (bus.line_buffer_out[0] !== 16'h8940) begin bad++; $display("FAIL col_above: got %h want 8940", bus.line_buffer_out[0]); end
            total++; if (bus.line_buffer_out[1] !== 16'h9140) begin bad++; $display("FAIL col_centre: got %h want 9140", bus.line_buffer_out[1]); end
            total++; if (bus.line_buffer_out[2] !== 16'h9940) begin bad++; $display("FAIL col_below: got %h want 9940", bus.line_buffer_out[2]); end
         end
      end
      exp_sel = next_sel(exp_sel);
      px(0, 0, 0, 16'h0);
   endtask

   task automatic test_top_edge();
      run_lines(0, 1, 0, 99);
      for (int h = 0; h < HRES; h++) begin
         px(h, 1, 1, pix(1, h));
         if (h == 8) begin
            total++;
            if (bus.vcount_out !== 10'd0 || bus.hcount_out !== 11'd7) begin
               bad++; $display("FAIL top_counts: got h=%0d v=%0d want 7/0", bus.hcount_out, bus.vcount_out);
            end
            total++; if (bus.line_buffer_out[0] !== 16'h00E0) begin bad++; $display("FAIL top_above: got %h want 00e0", bus.line_buffer_out[0]); end
            total++; if (bus.line_buffer_out[1] !== 16'h00E0) begin bad++; $display("FAIL top_centre: got %h want 00e0", bus.line_buffer_out[1]); end
            total++; if (bus.line_buffer_out[2] !== 16'h08E0) begin bad++; $display("FAIL top_below: got %h want 08e0", bus.line_buffer_out[2]); end
         end
      end
      exp_sel = next_sel(exp_sel);
      px(0, 0, 0, 16'h0);
   endtask

   task automatic test_bottom_edge();
      run_lines(178, 2, 0, 99);
      for (int h = 0; h < HRES; h++) begin
         px(h, 0, 1, pix(0, h));
         if (h == 8) begin
            total++;
            if (bus.vcount_out !== 10'd179 || bus.hcount_out !== 11'd7) begin
               bad++; $display("FAIL bot_counts: got h=%0d v=%0d want 7/179", bus.hcount_out, bus.vcount_out);
            end
            total++; if (bus.line_buffer_out[0] !== 16'h90E0) begin bad++; $display("FAIL bot_above: got %h want 90e0", bus.line_buffer_out[0]); end
            total++; if (bus.line_buffer_out[1] !== 16'h98E0) begin bad++; $display("FAIL bot_centre: got %h want 98e0", bus.line_buffer_out[1]); end
            total++; if (bus.line_buffer_out[2] !== 16'h98E0) begin bad++; $display("FAIL bot_below: got %h want 98e0", bus.line_buffer_out[2]); end
         end
      end
      exp_sel = next_sel(exp_sel);
      px(0, 0, 0, 16'h0);
   endtask

   task automatic test_gaps();
      run_lines(98, 5, 30, 2);
   endtask

   task automatic test_out_of_range();
      run_lines(60, 2, 0, 99);
      for (int h = 0; h < HRES; h++) begin
         if (h == 6) begin
            px(5, 200, 1, 16'hDEAD);
            px(400, 62, 1, 16'hBEEF);
            total++; if (bus.data_valid_out !== 1'b0) begin bad++; $display("FAIL oor_vcount: got %0b want 0", bus.data_valid_out); end
            px(319, 200, 1, 16'hDEAD);
            total++; if (bus.data_valid_out !== 1'b0) begin bad++; $display("FAIL oor_hcount: got %0b want 0", bus.data_valid_out); end
            total++; if (dut.wr_sel_q !== exp_sel) begin bad++; $display("FAIL oor_wr_sel: got %0d want %0d", dut.wr_sel_q, exp_sel); end
         end
         px(h, 62, 1, pix(62, h));
         if (h == 6) begin
            total++; if (bus.data_valid_out !== 1'b0) begin bad++; $display("FAIL oor_line_end: got %0b want 0", bus.data_valid_out); end
         end
      end
      exp_sel = next_sel(exp_sel);
      px(0, 0, 0, 16'h0);
      run_lines(63, 1, 0, 0);
   endtask

   task automatic test_reset_mid_line();
      for (int h = 0; h <= 150; h++) px(h, 70, 1, pix(70, h));
      rst = 1'b1;
      px(151, 70, 1, pix(70, 151));
      total++; if (bus.data_valid_out !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b want 0", bus.data_valid_out); end
      total++; if (bus.hcount_out !== 11'd0) begin bad++; $display("FAIL midrst_hcount: got %0d want 0", bus.hcount_out); end
      total++; if (bus.vcount_out !== 10'd0) begin bad++; $display("FAIL midrst_vcount: got %0d want 0", bus.vcount_out); end
      total++; if (bus.line_buffer_out !== 48'h0) begin bad++; $display("FAIL midrst_lbo: got %h want 0", bus.line_buffer_out); end
      total++; if (dut.wr_sel_q !== 2'd0) begin bad++; $display("FAIL midrst_wr_sel: got %0d want 0", dut.wr_sel_q); end
      rst = 1'b0;
      px(152, 70, 1, pix(70, 152));
      total++; if (bus.data_valid_out !== 1'b0) begin bad++; $display("FAIL midrst_hold: got %0b want 0", bus.data_valid_out); end
      px(153, 70, 1, pix(70, 153));
      total++;
      if (bus.data_valid_out !== 1'b1 || bus.hcount_out !== 11'd152) begin
         bad++; $display("FAIL midrst_resume: got vld=%0b h=%0d want 1/152", bus.data_valid_out, bus.hcount_out);
      end
      exp_sel = 2'd0;
      px(0, 0, 0, 16'h0);
   endtask

   initial begin
      bus.hcount_in     = '0;
      bus.vcount_in     = '0;
      bus.data_valid_in = 1'b0;
      bus.pixel_data_in = '0;
      test_reset();
      test_rotation();
      test_column();
      test_top_edge();
      test_bottom_edge();
      test_gaps();
      test_out_of_range();
      test_reset_mid_line();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
